// File: rtl/packet_buffer_stream_reader_pkg.sv
// Shared definitions for the packet buffer stream reader.
//   state_e            : control FSM states (IDLE, READ, DRAIN)
//   fifo_depth()       : output FIFO depth needed for a given RAM read latency
//   count_width()      : bits needed to hold an occupancy count 0..depth
//   read_latency_legal : only 1- and 2-cycle RAMs are supported
package packet_buffer_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Two extra slots beyond the read latency let the reader issue one word
  // per clock while the head word waits for the downstream handshake.
  function automatic int fifo_depth(input int read_latency);
    return read_latency + 2;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit read_latency_legal(input int read_latency);
    return (read_latency == 1) || (read_latency == 2);
  endfunction

endpackage

// File: rtl/packet_buffer_stream_reader_if.sv
// Bundle of all non-clock signals of the packet buffer stream reader.
//   Command  : start, start_address, packet_length, abort -> busy, done
//   RAM port : ram_read_address -> ram_read_data
//   Stream   : m_data, m_valid, m_last -> m_ready
// modport master is the reader itself; modport slave is its environment.
interface packet_buffer_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4096
);
  localparam int AW = $clog2(DATA_DEPTH);

  logic                  start;
  logic [AW-1:0]         start_address;
  logic [AW:0]           packet_length;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         ram_read_address;
  logic [DATA_WIDTH-1:0] ram_read_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    input  start, start_address, packet_length, abort, ram_read_data, m_ready,
    output busy, done, ram_read_address, m_data, m_valid, m_last
  );

  modport slave (
    output start, start_address, packet_length, abort, ram_read_data, m_ready,
    input  busy, done, ram_read_address, m_data, m_valid, m_last
  );

endinterface

// File: rtl/packet_buffer_stream_reader_stream_output_fifo.sv
// Small synchronous FIFO that decouples RAM read returns from the stream.
//   clock, reset : clock and asynchronous active-high reset
//   flush        : synchronous clear of all entries
//   push/push_data, pop : write and read strobes (pop ignored when empty)
//   head_data    : oldest entry, count : occupancy, empty : count == 0
// Push and pop in the same cycle are allowed at any occupancy, including full.
module stream_output_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: rtl/packet_buffer_stream_reader.sv
// Read-side engine for a packet held in a dual-port RAM.
//   clock, reset : single clock, asynchronous active-high reset
//   bus (master) : start/start_address/packet_length/abort command, busy/done
//                  status, ram_read_address/ram_read_data RAM read port,
//                  m_data/m_valid/m_ready/m_last output stream
// Reads are issued sequentially from start_address (wrapping at DATA_DEPTH).
// A tag pipe as long as the RAM latency marks which RAM return cycles carry
// packet data; tagged words land in a small FIFO that drives the stream.
module packet_buffer_stream_reader
  import packet_buffer_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_DEPTH   = 4096,
  parameter int READ_LATENCY = 2
) (
  input logic                    clock,
  input logic                    reset,
  packet_buffer_stream_reader_if.master bus
);

  localparam int AW         = $clog2(DATA_DEPTH);
  localparam int FIFO_DEPTH = fifo_depth(READ_LATENCY);
  localparam int CW         = count_width(FIFO_DEPTH);

  if (!read_latency_legal(READ_LATENCY)) begin : g_illegal_latency
    $error("packet_buffer_stream_reader: READ_LATENCY must be 1 or 2");
  end

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [AW:0]             words_q, words_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [READ_LATENCY-1:0] tag_last_q, tag_last_d;

  logic                    issue, issue_last, room;
  logic [CW-1:0]           in_flight;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [DATA_WIDTH:0]     fifo_head;
  logic                    push, pop, handshake;

  // Every word still in the tag pipe already has a FIFO slot reserved, so the
  // sum of in-flight reads and stored words bounds occupancy and the FIFO can
  // never overflow. The count uses FIFO occupancy before any same-edge pop.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + CW'(tag_valid_q[i]);
    end
  end

  assign room      = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign handshake = !fifo_empty && bus.m_ready;
  assign pop       = handshake;
  assign push      = tag_valid_q[READ_LATENCY-1];

  // Control FSM: IDLE waits for a non-empty command, READ issues addresses,
  // DRAIN waits for the last word to leave. Abort overrides everything.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    words_d    = words_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      words_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && (bus.packet_length != '0)) begin
            state_d = READ;
            addr_d  = bus.start_address;
            words_d = bus.packet_length;
          end
        end
        READ: begin
          if (room && (words_q != '0)) begin
            issue      = 1'b1;
            issue_last = (words_q == (AW+1)'(1));
            addr_d     = (addr_q == AW'(DATA_DEPTH - 1)) ? '0 : addr_q + 1'b1;
            words_d    = words_q - 1'b1;
            if (issue_last) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (handshake && fifo_head[DATA_WIDTH]) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Tag pipe mirrors the RAM latency; the last bit rides along with the valid
  // bit so the FIFO entry knows whether it closes the packet.
  always_comb begin
    tag_valid_d = '0;
    tag_last_d  = '0;
    if (!bus.abort) begin
      tag_valid_d[0] = issue;
      tag_last_d[0]  = issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid_d[i] = tag_valid_q[i-1];
        tag_last_d[i]  = tag_last_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      words_q     <= '0;
      done_q      <= 1'b0;
      tag_valid_q <= '0;
      tag_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      done_q      <= done_d;
      tag_valid_q <= tag_valid_d;
      tag_last_q  <= tag_last_d;
    end
  end

  stream_output_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1),
    .CW    (CW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (bus.abort),
    .push      (push),
    .push_data ({tag_last_q[READ_LATENCY-1], bus.ram_read_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.busy             = (state_q != IDLE);
  assign bus.done             = done_q;
  assign bus.ram_read_address = addr_q;
  assign bus.m_data           = fifo_head[DATA_WIDTH-1:0];
  assign bus.m_valid          = !fifo_empty;
  assign bus.m_last           = !fifo_empty && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_packet_buffer_stream_reader.sv
// Self-checking bench for packet_buffer_stream_reader. Two instances are
// built: one with a 2-cycle RAM and one with a 1-cycle RAM. The RAM content
// model is mem[a] = {4'hA, a}, so expected words are easy to derive by hand.
module tb_packet_buffer_stream_reader;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  logic        tb_start = 1'b0;
  logic        tb_abort = 1'b0;
  logic        tb_ready = 1'b0;
  logic        use_l1   = 1'b0;
  logic [11:0] tb_addr  = '0;
  logic [12:0] tb_len   = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  packet_buffer_stream_reader_if #(.DATA_WIDTH(16), .DATA_DEPTH(4096)) bus2 ();
  packet_buffer_stream_reader_if #(.DATA_WIDTH(16), .DATA_DEPTH(4096)) bus1 ();

  assign bus2.start         = tb_start & ~use_l1;
  assign bus1.start         = tb_start & use_l1;
  assign bus2.start_address = tb_addr;
  assign bus1.start_address = tb_addr;
  assign bus2.packet_length = tb_len;
  assign bus1.packet_length = tb_len;
  assign bus2.abort         = tb_abort;
  assign bus1.abort         = tb_abort;
  assign bus2.m_ready       = tb_ready;
  assign bus1.m_ready       = tb_ready;

  packet_buffer_stream_reader #(
    .DATA_WIDTH(16), .DATA_DEPTH(4096), .READ_LATENCY(2)
  ) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.master)
  );

  packet_buffer_stream_reader #(
    .DATA_WIDTH(16), .DATA_DEPTH(4096), .READ_LATENCY(1)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.master)
  );

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    return {4'hA, a};
  endfunction

  // RAM models: pipelined (2-cycle) and plain registered (1-cycle) reads.
  logic [15:0] ram2_stage;
  always @(posedge clock) begin
    ram2_stage         <= mem_word(bus2.ram_read_address);
    bus2.ram_read_data <= ram2_stage;
  end

  always @(posedge clock) begin
    bus1.ram_read_data <= mem_word(bus1.ram_read_address);
  end

  // Outputs of whichever instance is currently under test.
  logic        s_busy, s_done, s_valid, s_last;
  logic [11:0] s_addr;
  logic [15:0] s_data;
  assign s_busy  = use_l1 ? bus1.busy             : bus2.busy;
  assign s_done  = use_l1 ? bus1.done             : bus2.done;
  assign s_valid = use_l1 ? bus1.m_valid          : bus2.m_valid;
  assign s_last  = use_l1 ? bus1.m_last           : bus2.m_last;
  assign s_addr  = use_l1 ? bus1.ram_read_address : bus2.ram_read_address;
  assign s_data  = use_l1 ? bus1.m_data           : bus2.m_data;

  typedef struct {
    int          lat;
    logic [11:0] addr;
    logic [12:0] len;
    int          mode;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_first_valid;
    int          exp_max_out;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one packet: checks every beat against the RAM model, stall
  // stability, first-valid latency, outstanding-read bound and done/busy.
  task automatic applyStimulus(input vec_t v);
    int          cyc, beats, issued, first_valid, last_cyc, max_out, outstanding, limit;
    logic [11:0] prev_addr, a;
    logic [15:0] first_word, last_word, held_data;
    logic        held_last, stalled_prev, ready;
    use_l1 = (v.lat == 1);
    @(negedge clock);
    tb_addr  = v.addr;
    tb_len   = v.len;
    tb_start = 1'b1;
    tb_ready = (v.mode == 0);
    @(negedge clock);
    tb_start = 1'b0;
    checkOutput("busy_after_start", 32'(s_busy), 32'd1);
    checkOutput("addr_loaded", 32'(s_addr), 32'(v.addr));
    prev_addr    = s_addr;
    cyc          = 0;
    beats        = 0;
    issued       = 0;
    first_valid  = -1;
    last_cyc     = -1;
    max_out      = 0;
    stalled_prev = 1'b0;
    held_data    = '0;
    held_last    = 1'b0;
    first_word   = '0;
    last_word    = '0;
    limit        = int'(v.len) * 8 + 100;
    while ((beats < int'(v.len)) && (cyc < limit)) begin
      if (s_addr != prev_addr) begin
        issued++;
        prev_addr = s_addr;
      end
      outstanding = issued - beats;
      if (outstanding > max_out) max_out = outstanding;
      if (v.mode == 0) ready = 1'b1;
      else if (cyc < 8) ready = 1'b0;
      else if (cyc < 24) ready = (((cyc - 8) % 4) == 0) || (((cyc - 8) % 4) == 3);
      else ready = 1'($urandom_range(0, 1));
      tb_ready = ready;
      if (stalled_prev) begin
        checkOutput("stall_hold", {15'd0, s_valid, s_last, s_data},
                    {15'd0, 1'b1, held_last, held_data});
      end
      if (s_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (ready) begin
          a = v.addr + 12'(beats);
          checkOutput("beat_data", 32'(s_data), 32'(mem_word(a)));
          checkOutput("beat_last", 32'(s_last), 32'(beats == int'(v.len) - 1));
          if (beats == 0) first_word = s_data;
          if (beats == int'(v.len) - 1) begin
            last_word = s_data;
            last_cyc  = cyc;
          end
          beats++;
        end
      end
      stalled_prev = s_valid && !ready;
      held_data    = s_data;
      held_last    = s_last;
      @(negedge clock);
      cyc++;
    end
    checkOutput("beat_count", 32'(beats), 32'(v.len));
    checkOutput("done_pulse", 32'(s_done), 32'd1);
    checkOutput("busy_at_done", 32'(s_busy), 32'd0);
    checkOutput("issued", 32'(issued), 32'(v.len));
    checkOutput("first_word", 32'(first_word), 32'(v.exp_first));
    checkOutput("last_word", 32'(last_word), 32'(v.exp_last));
    checkOutput("max_outstanding", 32'(max_out), 32'(v.exp_max_out));
    if (v.exp_first_valid >= 0) begin
      checkOutput("first_valid_cycle", 32'(first_valid), 32'(v.exp_first_valid));
      checkOutput("no_bubbles", 32'(last_cyc - first_valid), 32'(int'(v.len) - 1));
    end
    @(negedge clock);
    checkOutput("done_one_cycle", 32'(s_done), 32'd0);
    checkOutput("idle_valid", 32'(s_valid), 32'd0);
  endtask

  initial begin
    int          beats, cyc;
    logic        saw_done, saw_valid, saw_busy;
    logic [11:0] a;

    vecs[0] = '{2, 12'h010, 13'd4,    0, 16'hA010, 16'hA013,  3, 3};
    vecs[1] = '{2, 12'hFFE, 13'd4,    0, 16'hAFFE, 16'hA001,  3, 3};
    vecs[2] = '{2, 12'h100, 13'd16,   1, 16'hA100, 16'hA10F, -1, 4};
    vecs[3] = '{2, 12'h7FF, 13'd1,    0, 16'hA7FF, 16'hA7FF,  3, 1};
    vecs[4] = '{1, 12'h020, 13'd8,    0, 16'hA020, 16'hA027,  2, 2};
    vecs[5] = '{2, 12'h000, 13'd4096, 0, 16'hA000, 16'hAFFF,  3, 3};

    // Reset state
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_busy", 32'(s_busy), 32'd0);
    checkOutput("reset_done", 32'(s_done), 32'd0);
    checkOutput("reset_addr", 32'(s_addr), 32'd0);
    checkOutput("reset_data", 32'(s_data), 32'd0);
    checkOutput("reset_valid", 32'(s_valid), 32'd0);
    checkOutput("reset_last", 32'(s_last), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end
    use_l1 = 1'b0;

    // Zero-length start is ignored
    @(negedge clock);
    tb_addr  = 12'h123;
    tb_len   = 13'd0;
    tb_start = 1'b1;
    @(negedge clock);
    tb_start  = 1'b0;
    saw_done  = 1'b0;
    saw_valid = 1'b0;
    saw_busy  = s_busy;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      saw_done  = saw_done | s_done;
      saw_valid = saw_valid | s_valid;
      saw_busy  = saw_busy | s_busy;
    end
    checkOutput("zero_len_busy", 32'(saw_busy), 32'd0);
    checkOutput("zero_len_done", 32'(saw_done), 32'd0);
    checkOutput("zero_len_valid", 32'(saw_valid), 32'd0);

    // Abort after 3 of 10 words; a start while busy must be ignored
    @(negedge clock);
    tb_addr  = 12'h200;
    tb_len   = 13'd10;
    tb_start = 1'b1;
    tb_ready = 1'b1;
    @(negedge clock);
    tb_start = 1'b0;
    beats    = 0;
    cyc      = 0;
    while ((beats < 3) && (cyc < 20)) begin
      if (cyc == 1) begin
        tb_addr  = 12'h500;
        tb_len   = 13'd2;
        tb_start = 1'b1;
      end else begin
        tb_start = 1'b0;
      end
      if (s_valid) begin
        a = 12'h200 + 12'(beats);
        checkOutput("abort_pkt_data", 32'(s_data), 32'(mem_word(a)));
        beats++;
      end
      @(negedge clock);
      cyc++;
    end
    tb_start = 1'b0;
    checkOutput("abort_pkt_beats", 32'(beats), 32'd3);
    tb_abort = 1'b1;
    tb_ready = 1'b0;
    @(negedge clock);
    tb_abort = 1'b0;
    checkOutput("abort_valid", 32'(s_valid), 32'd0);
    checkOutput("abort_busy", 32'(s_busy), 32'd0);
    saw_done  = s_done;
    saw_valid = 1'b0;
    tb_ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      saw_done  = saw_done | s_done;
      saw_valid = saw_valid | s_valid;
    end
    checkOutput("abort_no_done", 32'(saw_done), 32'd0);
    checkOutput("abort_flushed", 32'(saw_valid), 32'd0);

    // Start and abort together in IDLE: abort wins
    tb_addr  = 12'h040;
    tb_len   = 13'd5;
    tb_start = 1'b1;
    tb_abort = 1'b1;
    @(negedge clock);
    tb_start = 1'b0;
    tb_abort = 1'b0;
    checkOutput("start_abort_busy", 32'(s_busy), 32'd0);

    applyStimulus(vecs[0]);
    use_l1 = 1'b0;

    // Asynchronous reset mid-packet
    @(negedge clock);
    tb_addr  = 12'h300;
    tb_len   = 13'd8;
    tb_start = 1'b1;
    tb_ready = 1'b0;
    @(negedge clock);
    tb_start = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("pre_reset_valid", 32'(s_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", 32'(s_busy), 32'd0);
    checkOutput("async_reset_done", 32'(s_done), 32'd0);
    checkOutput("async_reset_addr", 32'(s_addr), 32'd0);
    checkOutput("async_reset_data", 32'(s_data), 32'd0);
    checkOutput("async_reset_valid", 32'(s_valid), 32'd0);
    checkOutput("async_reset_last", 32'(s_last), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
